// File: rtl/aurora_loopback_responder.sv
// Aurora far-end loopback responder: buffers the RX word stream in a small
// circular FIFO and retransmits it unchanged on TX. It also keeps sticky
// link, overflow and soft-error status for the board LEDs.
module aurora_loopback_responder #(
  parameter int DATA_WIDTH = 16,
  parameter int N_LANE     = 1,
  parameter int FIFO_AW    = 4
) (
  input  logic                  USER_CLK,
  input  logic                  RESET,
  input  logic                  CHANNEL_UP,
  input  logic [N_LANE-1:0]     LANE_UP,
  input  logic                  HARD_ERR,
  input  logic                  SOFT_ERR,
  input  logic [0:DATA_WIDTH-1] RX_D,
  input  logic                  RX_SRC_RDY_N,
  input  logic                  TX_DST_RDY_N,
  output logic [0:DATA_WIDTH-1] TX_D,
  output logic                  TX_SRC_RDY_N,
  output logic [31:0]           N_ECHOED,
  output logic [7:0]            GPIO_LED
);

  localparam logic [1:0] S_WAIT  = 2'd0;
  localparam logic [1:0] S_UP    = 2'd1;
  localparam logic [1:0] S_ERROR = 2'd2;

  localparam int               DEPTH      = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_COUNT = (FIFO_AW + 1)'(DEPTH);

  logic [1:0]            state;
  logic [FIFO_AW-1:0]    wr_ptr;
  logic [FIFO_AW-1:0]    rd_ptr;
  logic [FIFO_AW:0]      count;
  logic [0:DATA_WIDTH-1] mem [DEPTH];
  logic [31:0]           n_echoed_q;
  logic [7:0]            n_soft;
  logic [27:0]           n_clock;
  logic                  ovf_sticky;

  logic tx_valid;
  logic run;
  logic flush;
  logic full;
  logic push_req;
  logic push;
  logic pop;
  logic overflow;

  // Decode this cycle's push/pop and the flush/overflow conditions.
  // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
  always_comb begin
    tx_valid = (state == S_UP) && (count != '0);
    run      = (state == S_UP) && !HARD_ERR && CHANNEL_UP;
    flush    = (state == S_WAIT) || ((state == S_UP) && !HARD_ERR && !CHANNEL_UP);
    full     = (count == FULL_COUNT);
    push_req = run && !RX_SRC_RDY_N;
    pop      = run && tx_valid && !TX_DST_RDY_N;
    overflow = push_req && full && !pop;
    push     = push_req && !overflow;
  end

  // Link state machine; ERROR is left only through RESET.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge USER_CLK) begin
    if (RESET) begin
      state      <= S_WAIT;
      ovf_sticky <= 1'b0;
    end else begin
      case (state)
        S_WAIT:  if (CHANNEL_UP) state <= S_UP;
        S_UP: begin
          if (HARD_ERR) begin
            state <= S_ERROR;
          end else if (!CHANNEL_UP) begin
            state <= S_WAIT;
          end else if (overflow) begin
            state      <= S_ERROR;
            ovf_sticky <= 1'b1;
          end
        end
        S_ERROR: state <= S_ERROR;
        default: state <= S_WAIT;
      endcase
    end
  end

  // FIFO pointers and occupancy; WAIT and a channel drop empty the FIFO.
  always_ff @(posedge USER_CLK) begin
    if (RESET || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Echo storage written on accepted pushes.
  // NOTE: the array has no reset; stale contents are never visible because TX is invalid while count is zero.
  always_ff @(posedge USER_CLK) begin
    if (push) mem[wr_ptr] <= RX_D;
  end

  // Echo counter, saturating soft-error counter and heartbeat.
  always_ff @(posedge USER_CLK) begin
    if (RESET) begin
      n_echoed_q <= '0;
      n_soft     <= '0;
      n_clock    <= '0;
    end else begin
      n_echoed_q <= n_echoed_q + 32'(pop);
      if (SOFT_ERR && (n_soft != 8'hFF)) n_soft <= n_soft + 1'b1;
      n_clock    <= n_clock + 1'b1;
    end
  end

  assign TX_D         = mem[rd_ptr];
  assign TX_SRC_RDY_N = ~tx_valid;
  assign N_ECHOED     = n_echoed_q;
  assign GPIO_LED     = {state == S_ERROR, ovf_sticky, CHANNEL_UP, LANE_UP[0],
                         |n_soft, state == S_UP, count != '0, n_clock[27]};

endmodule

// File: tb/tb_aurora_loopback_responder.sv
// Self-checking bench for aurora_loopback_responder: directed steps with a
// scoreboard queue filled on accepted RX words and drained on TX pops.
module tb_aurora_loopback_responder;

  localparam int DW = 16;

  logic          USER_CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          CHANNEL_UP = 1'b0;
  logic [0:0]    LANE_UP = 1'b0;
  logic          HARD_ERR = 1'b0;
  logic          SOFT_ERR = 1'b0;
  logic [0:DW-1] RX_D = '0;
  logic          RX_SRC_RDY_N = 1'b1;
  logic          TX_DST_RDY_N = 1'b1;
  logic [0:DW-1] TX_D;
  logic          TX_SRC_RDY_N;
  logic [31:0]   N_ECHOED;
  logic [7:0]    GPIO_LED;

  int            n_asserts = 0;
  int            n_fail = 0;
  logic [DW-1:0] sb [$];

  aurora_loopback_responder #(.DATA_WIDTH(DW), .N_LANE(1), .FIFO_AW(4)) dut (
    .USER_CLK    (USER_CLK),
    .RESET       (RESET),
    .CHANNEL_UP  (CHANNEL_UP),
    .LANE_UP     (LANE_UP),
    .HARD_ERR    (HARD_ERR),
    .SOFT_ERR    (SOFT_ERR),
    .RX_D        (RX_D),
    .RX_SRC_RDY_N(RX_SRC_RDY_N),
    .TX_DST_RDY_N(TX_DST_RDY_N),
    .TX_D        (TX_D),
    .TX_SRC_RDY_N(TX_SRC_RDY_N),
    .N_ECHOED    (N_ECHOED),
    .GPIO_LED    (GPIO_LED)
  );

  always #5 USER_CLK = ~USER_CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge: drive one cycle of inputs, score the
  // word the DUT will pop at the coming edge, record an accepted RX word.
  task automatic cycle(input logic rx_v, input logic [DW-1:0] rx_w,
                       input logic dst_n, input bit accept);
    logic [DW-1:0] exp;
    RX_SRC_RDY_N = ~rx_v;
    RX_D         = rx_w;
    TX_DST_RDY_N = dst_n;
    if (TX_SRC_RDY_N === 1'b0 && !dst_n && CHANNEL_UP && !HARD_ERR && !RESET) begin
      if (sb.size() == 0) begin
        check("tx_unexpected_word", 32'(TX_D), 32'hFFFF_FFFF);
      end else begin
        exp = sb.pop_front();
        check("tx_order", 32'(TX_D), 32'(exp));
      end
    end
    if (rx_v && accept) sb.push_back(rx_w);
    @(negedge USER_CLK);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) cycle(1'b0, '0, 1'b0, 1'b0);
    check("drain_empty", 32'(sb.size()), 32'd0);
    check("drain_idle", 32'(TX_SRC_RDY_N), 32'd1);
  endtask

  task automatic do_reset();
    RESET = 1'b1; CHANNEL_UP = 1'b0; LANE_UP = 1'b0; HARD_ERR = 1'b0; SOFT_ERR = 1'b0;
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    RESET = 1'b0;
    sb.delete();
  endtask

  task automatic bring_up();
    CHANNEL_UP = 1'b1; LANE_UP = 1'b1;
    cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    @(negedge USER_CLK);

    // Reset state
    do_reset();
    check("rst_tx_rdy_n", 32'(TX_SRC_RDY_N), 32'd1);
    check("rst_n_echoed", N_ECHOED, 32'd0);
    check("rst_led", 32'(GPIO_LED), 32'h00);

    // WAIT->UP: the word present in the transition cycle is ignored
    CHANNEL_UP = 1'b1; LANE_UP = 1'b1;
    cycle(1'b1, 16'hDEAD, 1'b0, 1'b0);
    check("up_led", 32'(GPIO_LED), 32'h34);
    check("up_empty_tx_rdy_n", 32'(TX_SRC_RDY_N), 32'd1);

    // Back-to-back stream 0..99 with TX always ready
    cycle(1'b1, 16'd0, 1'b0, 1'b1);
    check("latency_tx_rdy_n", 32'(TX_SRC_RDY_N), 32'd0);
    check("latency_tx_d", 32'(TX_D), 32'd0);
    for (int k = 1; k < 100; k++) cycle(1'b1, 16'(k), 1'b0, 1'b1);
    drain();
    check("stream_n_echoed", N_ECHOED, 32'd100);
    check("stream_led_7_6", 32'(GPIO_LED[7:6]), 32'd0);

    // Overflow: 16 words fill the FIFO, the 17th goes to ERROR
    do_reset();
    bring_up();
    for (int i = 0; i < 16; i++) cycle(1'b1, 16'(16'h1000 + i), 1'b1, 1'b1);
    check("full_led_7_6", 32'(GPIO_LED[7:6]), 32'd0);
    check("full_tx_rdy_n", 32'(TX_SRC_RDY_N), 32'd0);
    cycle(1'b1, 16'h10FF, 1'b1, 1'b0);
    check("ovf_led_7_6", 32'(GPIO_LED[7:6]), 32'd3);
    check("ovf_tx_rdy_n", 32'(TX_SRC_RDY_N), 32'd1);
    check("ovf_count_frozen", 32'(dut.count), 32'd16);
    CHANNEL_UP = 1'b0;
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'h10EE, 1'b0, 1'b0);
    CHANNEL_UP = 1'b1;
    check("ovf_sticky_error", 32'(GPIO_LED[7:6]), 32'd3);
    check("ovf_no_pop", N_ECHOED, 32'd0);
    do_reset();
    check("ovf_reset_led", 32'(GPIO_LED), 32'h00);
    check("ovf_reset_tx_rdy_n", 32'(TX_SRC_RDY_N), 32'd1);

    // Full FIFO with simultaneous push and pop every cycle
    bring_up();
    for (int i = 0; i < 16; i++) cycle(1'b1, 16'(16'h2000 + i), 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) cycle(1'b1, 16'(16'h2010 + i), 1'b0, 1'b1);
    check("full_pp_count", 32'(dut.count), 32'd16);
    check("full_pp_no_ovf", 32'(GPIO_LED[7:6]), 32'd0);
    drain();
    check("full_pp_n_echoed", N_ECHOED, 32'd36);

    // Channel drop flushes buffered words; new words echo without stale data
    for (int i = 0; i < 5; i++) cycle(1'b1, 16'(16'h3000 + i), 1'b1, 1'b1);
    check("flush_pre_count_nz", 32'(GPIO_LED[1]), 32'd1);
    CHANNEL_UP = 1'b0;
    cycle(1'b1, 16'h30FF, 1'b0, 1'b0);
    sb.delete();
    check("flush_wait", 32'(GPIO_LED[2:1]), 32'd0);
    check("flush_tx_rdy_n", 32'(TX_SRC_RDY_N), 32'd1);
    CHANNEL_UP = 1'b1;
    cycle(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b1, 16'(16'hA000 + i), 1'b0, 1'b1);
    drain();
    check("flush_n_echoed", N_ECHOED, 32'd44);

    // Hard error during streaming freezes the echo path
    for (int i = 0; i < 6; i++) cycle(1'b1, 16'(16'h4000 + i), 1'b0, 1'b1);
    HARD_ERR = 1'b1;
    cycle(1'b1, 16'h40FF, 1'b0, 1'b0);
    HARD_ERR = 1'b0;
    check("herr_tx_rdy_n", 32'(TX_SRC_RDY_N), 32'd1);
    check("herr_led_7_6", 32'(GPIO_LED[7:6]), 32'd2);
    check("herr_n_echoed", N_ECHOED, 32'd49);
    for (int i = 0; i < 4; i++) cycle(1'b1, 16'h40EE, 1'b0, 1'b0);
    check("herr_n_echoed_frozen", N_ECHOED, 32'd49);

    // Soft errors saturate while data keeps flowing
    do_reset();
    bring_up();
    SOFT_ERR = 1'b1;
    for (int i = 0; i < 300; i++) cycle(1'b1, 16'(16'h5000 + i), 1'b0, 1'b1);
    SOFT_ERR = 1'b0;
    drain();
    check("soft_n_soft_sat", 32'(dut.n_soft), 32'd255);
    check("soft_led3", 32'(GPIO_LED[3]), 32'd1);
    check("soft_n_echoed", N_ECHOED, 32'd300);

    // Echo counter wraps at 2^32
    force dut.n_echoed_q = 32'hFFFF_FFFE;
    cycle(1'b0, '0, 1'b1, 1'b0);
    release dut.n_echoed_q;
    check("wrap_preload", N_ECHOED, 32'hFFFF_FFFE);
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'(16'h6000 + i), 1'b0, 1'b1);
    drain();
    check("wrap_n_echoed", N_ECHOED, 32'd1);

    // RESET mid-transfer discards buffered words and clears status
    for (int i = 0; i < 4; i++) cycle(1'b1, 16'(16'h7000 + i), 1'b1, 1'b1);
    RESET = 1'b1;
    cycle(1'b1, 16'h70FF, 1'b0, 1'b0);
    sb.delete();
    check("midrst_led", 32'(GPIO_LED), 32'h30);
    check("midrst_tx_rdy_n", 32'(TX_SRC_RDY_N), 32'd1);
    check("midrst_n_echoed", N_ECHOED, 32'd0);
    RESET = 1'b0;
    cycle(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 16'(16'h8000 + i), 1'b0, 1'b1);
    drain();
    check("midrst_n_echoed_after", N_ECHOED, 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
